// File: rtl/data_mem_xbar_pkg.sv
// Shared constants and address helpers for the banked scratchpad request crossbar.
// Banks are word-interleaved: the bank index sits directly above the byte offset.
package data_mem_xbar_pkg;

    localparam int NUM_MASTERS_DFLT     = 4;
    localparam int NUM_BANKS_DFLT       = 4;
    localparam int MAX_OUTSTANDING_DFLT = 4;
    localparam int RSP_FIFO_DEPTH_DFLT  = 4;

    localparam int BANK_IDX_W = $clog2(NUM_BANKS_DFLT);
    localparam int MST_ID_W   = $clog2(NUM_MASTERS_DFLT);

    // Callers truncate the result to their own bank-index width.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_w);
        return (addr >> 2) & ((32'd1 << bank_w) - 32'd1);
    endfunction

    // Word address inside one bank: the bank field is squeezed out, byte offset kept.
    function automatic logic [31:0] bank_local_addr(input logic [31:0] addr, input int bank_w);
        return ((addr >> (bank_w + 2)) << 2) | {30'd0, addr[1:0]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered pointer,
// pointer moves past the winner only when the caller signals a completed handshake.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             found;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (!found && req_i[PTR_W'(idx)]) begin
                found                = 1'b1;
                gnt_o[PTR_W'(idx)]   = 1'b1;
                win_idx              = PTR_W'(idx);
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_mem_xbar.sv
// Request crossbar from LSU lanes to word-interleaved scratchpad banks. Grants and
// responses are combinational; a per-bank master-ID FIFO steers read data back.
module data_mem_xbar
    import data_mem_xbar_pkg::*;
#(
    parameter int NUM_MASTERS        = NUM_MASTERS_DFLT,
    parameter int DATA_MEM_NUM_BANKS = NUM_BANKS_DFLT,
    parameter int MAX_OUTSTANDING    = MAX_OUTSTANDING_DFLT,
    parameter int RSP_FIFO_DEPTH     = RSP_FIFO_DEPTH_DFLT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_MASTERS-1:0]          mst_req_i,
    output logic [NUM_MASTERS-1:0]          mst_gnt_o,
    input  logic [NUM_MASTERS*32-1:0]       mst_addr_i,
    input  logic [NUM_MASTERS-1:0]          mst_we_i,
    input  logic [NUM_MASTERS*4-1:0]        mst_be_i,
    input  logic [NUM_MASTERS*32-1:0]       mst_wdata_i,
    output logic [NUM_MASTERS-1:0]          mst_rvalid_o,
    output logic [NUM_MASTERS*32-1:0]       mst_rdata_o,
    output logic [DATA_MEM_NUM_BANKS-1:0]    data_mem_req_o,
    input  logic [DATA_MEM_NUM_BANKS-1:0]    data_mem_gnt_i,
    output logic [DATA_MEM_NUM_BANKS*32-1:0] data_mem_addr_o,
    output logic [DATA_MEM_NUM_BANKS-1:0]    data_mem_we_o,
    output logic [DATA_MEM_NUM_BANKS*4-1:0]  data_mem_be_o,
    output logic [DATA_MEM_NUM_BANKS*32-1:0] data_mem_wdata_o,
    input  logic [DATA_MEM_NUM_BANKS-1:0]    data_mem_rvalid_i,
    input  logic [DATA_MEM_NUM_BANKS*32-1:0] data_mem_rdata_i
);

    localparam int BANK_W = $clog2(DATA_MEM_NUM_BANKS);
    localparam int ID_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);

    logic [BANK_W-1:0]      mst_bank    [NUM_MASTERS];
    logic [31:0]            mst_local   [NUM_MASTERS];
    logic [OUT_W-1:0]       outstanding [NUM_MASTERS];
    logic [BANK_W-1:0]      last_bank   [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] mst_drained;

    logic [DATA_MEM_NUM_BANKS-1:0] bank_req;
    logic [DATA_MEM_NUM_BANKS-1:0] bank_hs;
    logic [DATA_MEM_NUM_BANKS-1:0] bank_rsp;
    logic [NUM_MASTERS-1:0]        bank_win  [DATA_MEM_NUM_BANKS];
    logic [ID_W-1:0]               bank_head [DATA_MEM_NUM_BANKS];

    // Marks the first cycle after reset, when stale bank responses may still arrive.
    logic post_rst_q;
    logic post_rst_d;
    assign post_rst_d = !rst_ni;
    always_ff @(posedge clk_i) begin
        post_rst_q <= post_rst_d;
    end

    for (genvar gi = 0; gi < DATA_MEM_NUM_BANKS; gi++) begin : g_bank
        logic [NUM_MASTERS-1:0] elig;
        logic [NUM_MASTERS-1:0] win;
        logic [ID_W-1:0]        win_id;
        logic [31:0]            addr_sel;
        logic                   we_sel;
        logic [3:0]             be_sel;
        logic [31:0]            wdata_sel;
        logic                   fifo_full;
        logic [ID_W-1:0]        fifo_mem_q [RSP_FIFO_DEPTH];
        logic [ID_W-1:0]        fifo_mem_d [RSP_FIFO_DEPTH];
        logic [PTR_W-1:0]       head_q, head_d;
        logic [PTR_W-1:0]       tail_q, tail_d;
        logic [CNT_W-1:0]       count_q, count_d;

        // A master only switches banks once its previous bank has fully answered.
        always_comb begin
            elig = '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                elig[m] = mst_req_i[m]
                       && (mst_bank[m] == BANK_W'(gi))
                       && (outstanding[m] < OUT_W'(MAX_OUTSTANDING))
                       && (mst_drained[m] || (last_bank[m] == BANK_W'(gi)));
            end
        end

        rr_arbiter #(.N(NUM_MASTERS)) u_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (elig),
            .advance_i (bank_hs[gi]),
            .gnt_o     (win)
        );

        always_comb begin
            win_id    = '0;
            addr_sel  = '0;
            we_sel    = 1'b0;
            be_sel    = '0;
            wdata_sel = '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (win[m]) begin
                    win_id    = ID_W'(m);
                    addr_sel  = mst_local[m];
                    we_sel    = mst_we_i[m];
                    be_sel    = mst_be_i[m*4 +: 4];
                    wdata_sel = mst_wdata_i[m*32 +: 32];
                end
            end
        end

        // Registered occupancy: a pop this cycle cannot make room for a push this cycle.
        assign fifo_full    = (count_q == CNT_W'(RSP_FIFO_DEPTH));
        assign bank_req[gi] = rst_ni && (|elig) && !fifo_full;
        assign bank_hs[gi]  = bank_req[gi] && data_mem_gnt_i[gi];
        assign bank_rsp[gi] = rst_ni && data_mem_rvalid_i[gi] && (count_q != '0);
        assign bank_head[gi] = fifo_mem_q[head_q];
        assign bank_win[gi]  = win;

        assign data_mem_req_o[gi]           = bank_req[gi];
        assign data_mem_addr_o[gi*32 +: 32]  = addr_sel;
        assign data_mem_we_o[gi]            = we_sel;
        assign data_mem_be_o[gi*4 +: 4]      = be_sel;
        assign data_mem_wdata_o[gi*32 +: 32] = wdata_sel;

        always_comb begin
            fifo_mem_d = fifo_mem_q;
            head_d     = head_q;
            tail_d     = tail_q;
            if (bank_hs[gi]) begin
                fifo_mem_d[tail_q] = win_id;
                tail_d = (tail_q == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (bank_rsp[gi]) begin
                head_d = (head_q == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(bank_hs[gi]) - CNT_W'(bank_rsp[gi]);
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end

        always_ff @(posedge clk_i) begin
            fifo_mem_q <= fifo_mem_d;
        end

        a_rvalid_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(data_mem_rvalid_i[gi] && (count_q == '0) && !post_rst_q));
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
        logic [OUT_W-1:0]  outstanding_q, outstanding_d;
        logic [BANK_W-1:0] last_bank_q, last_bank_d;
        logic              hs;
        logic              rsp;
        logic [31:0]       rdata;
        logic [BANK_W:0]   rsp_cnt;

        assign mst_bank[gi]  = BANK_W'(bank_of(mst_addr_i[gi*32 +: 32], BANK_W));
        assign mst_local[gi] = bank_local_addr(mst_addr_i[gi*32 +: 32], BANK_W);

        always_comb begin
            hs      = 1'b0;
            rsp     = 1'b0;
            rdata   = '0;
            rsp_cnt = '0;
            for (int b = 0; b < DATA_MEM_NUM_BANKS; b++) begin
                if (bank_hs[b] && bank_win[b][gi]) begin
                    hs = 1'b1;
                end
                if (bank_rsp[b] && (bank_head[b] == ID_W'(gi))) begin
                    rsp     = 1'b1;
                    rdata   = data_mem_rdata_i[b*32 +: 32];
                    rsp_cnt = rsp_cnt + 1'b1;
                end
            end
            outstanding_d = outstanding_q + OUT_W'(hs) - OUT_W'(rsp);
            last_bank_d   = hs ? mst_bank[gi] : last_bank_q;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                outstanding_q <= '0;
                last_bank_q   <= '0;
            end else begin
                outstanding_q <= outstanding_d;
                last_bank_q   <= last_bank_d;
            end
        end

        // The last response returning this cycle lets a new bank be granted right away.
        assign mst_drained[gi] = (outstanding_q == '0) || ((outstanding_q == OUT_W'(1)) && rsp);
        assign outstanding[gi] = outstanding_q;
        assign last_bank[gi]   = last_bank_q;

        assign mst_gnt_o[gi]             = hs;
        assign mst_rvalid_o[gi]          = rsp;
        assign mst_rdata_o[gi*32 +: 32]  = rdata;

        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(rsp && (outstanding_q == '0)));
        a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(hs && !rsp && (outstanding_q == OUT_W'(MAX_OUTSTANDING))));
        a_single_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            rsp_cnt <= (BANK_W+1)'(1));
    end

endmodule

// File: tb/tb_data_mem_xbar.sv
// Directed bench for data_mem_xbar: a per-cycle vector table for routing, rotation
// and parallel traffic, then hand-written sequences for ordering, limits and reset.
module tb_data_mem_xbar;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req, gnt, we, rvalid;
    logic [127:0] addr, wdata, rdata;
    logic [15:0]  be;
    logic [3:0]   breq, bgnt, bwe, brv;
    logic [127:0] baddr, bwdata, brdata;
    logic [15:0]  bbe;

    int errors = 0;
    int checks = 0;

    data_mem_xbar dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .mst_req_i         (req),
        .mst_gnt_o         (gnt),
        .mst_addr_i        (addr),
        .mst_we_i          (we),
        .mst_be_i          (be),
        .mst_wdata_i       (wdata),
        .mst_rvalid_o      (rvalid),
        .mst_rdata_o       (rdata),
        .data_mem_req_o    (breq),
        .data_mem_gnt_i    (bgnt),
        .data_mem_addr_o   (baddr),
        .data_mem_we_o     (bwe),
        .data_mem_be_o     (bbe),
        .data_mem_wdata_o  (bwdata),
        .data_mem_rvalid_i (brv),
        .data_mem_rdata_i  (brdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [3:0]   req;
        logic [127:0] addr;
        logic [3:0]   bgnt;
        logic [3:0]   brv;
        logic [127:0] brdata;
        logic [3:0]   e_gnt;
        logic [3:0]   e_breq;
        logic [3:0]   e_rv;
        logic [127:0] e_rdata;
        logic [127:0] e_baddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t blank();
        vec_t v;
        v.rst_n = 1'b1;  v.req = '0;     v.addr = '0;    v.bgnt = 4'hF;
        v.brv = '0;      v.brdata = '0;  v.e_gnt = '0;   v.e_breq = '0;
        v.e_rv = '0;     v.e_rdata = '0; v.e_baddr = '0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req = '0; addr = '0; we = '0; be = '0; wdata = '0;
        bgnt = 4'hF; brv = '0; brdata = '0;
    endtask

    task automatic set_req(input int m, input logic [31:0] a);
        req[m] = 1'b1;
        addr[m*32 +: 32] = a;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;

        // Reset with all masters requesting: nothing may leak out.
        v = blank(); v.rst_n = 1'b0; v.req = 4'hF;
        for (int m = 0; m < 4; m++) v.addr[m*32 +: 32] = 32'h8;
        vecs.push_back(v);
        // Master 0 reads 0x14: bank 1, local 0x04.
        v = blank(); v.req = 4'b0001; v.addr[31:0] = 32'h14;
        v.e_gnt = 4'b0001; v.e_breq = 4'b0010; v.e_baddr[63:32] = 32'h4;
        vecs.push_back(v);
        v = blank(); v.brv = 4'b0010; v.brdata[63:32] = 32'hA1A1_0001;
        v.e_rv = 4'b0001; v.e_rdata[31:0] = 32'hA1A1_0001;
        vecs.push_back(v);
        // Four masters, four distinct banks, crossed mapping.
        v = blank(); v.req = 4'hF;
        v.addr[31:0] = 32'h40F; v.addr[63:32] = 32'h30A; v.addr[95:64] = 32'h100; v.addr[127:96] = 32'h204;
        v.e_gnt = 4'hF; v.e_breq = 4'hF;
        v.e_baddr[31:0] = 32'h40; v.e_baddr[63:32] = 32'h80; v.e_baddr[95:64] = 32'hC2; v.e_baddr[127:96] = 32'h103;
        vecs.push_back(v);
        v = blank(); v.brv = 4'hF;
        for (int b = 0; b < 4; b++) v.brdata[b*32 +: 32] = 32'hB000_0000 + b;
        v.e_rv = 4'hF;
        v.e_rdata[31:0] = 32'hB000_0003; v.e_rdata[63:32] = 32'hB000_0002;
        v.e_rdata[95:64] = 32'hB000_0000; v.e_rdata[127:96] = 32'hB000_0001;
        vecs.push_back(v);
        // Fresh reset, then all four masters hammer bank 2 with latency 1.
        v = blank(); v.rst_n = 1'b0; vecs.push_back(v);
        for (int r = 0; r < 8; r++) begin
            v = blank(); v.req = 4'hF;
            for (int m = 0; m < 4; m++) v.addr[m*32 +: 32] = 32'h08 + 32'h10 * m;
            v.e_gnt = 4'(1 << (r % 4)); v.e_breq = 4'b0100;
            v.e_baddr[95:64] = 32'(4 * (r % 4));
            if (r > 0) begin
                v.brv = 4'b0100;
                v.brdata[95:64] = 32'hC000_0000 + 32'(r - 1);
                v.e_rv = 4'(1 << ((r - 1) % 4));
                v.e_rdata[((r - 1) % 4)*32 +: 32] = 32'hC000_0000 + 32'(r - 1);
            end
            vecs.push_back(v);
        end
        v = blank(); v.brv = 4'b0100; v.brdata[95:64] = 32'hC000_0007;
        v.e_rv = 4'b1000; v.e_rdata[127:96] = 32'hC000_0007;
        vecs.push_back(v);

        drive_idle();
        rst_n = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; req = vecs[i].req; addr = vecs[i].addr;
            bgnt = vecs[i].bgnt; brv = vecs[i].brv; brdata = vecs[i].brdata;
            at_neg();
            chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d breq", i), 32'(breq), 32'(vecs[i].e_breq));
            chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].e_rv));
            for (int m = 0; m < 4; m++) begin
                if (vecs[i].e_rv[m])
                    chk($sformatf("v%0d rdata%0d", i, m), rdata[m*32 +: 32], vecs[i].e_rdata[m*32 +: 32]);
                if (vecs[i].e_breq[m])
                    chk($sformatf("v%0d baddr%0d", i, m), baddr[m*32 +: 32], vecs[i].e_baddr[m*32 +: 32]);
            end
            $display("vec %0d: gnt=%b breq=%b rvalid=%b", i, gnt, breq, rvalid);
            next_cycle();
        end

        // Ordering rule: master 1 cannot move to bank 3 until bank 0 answers.
        do_reset();
        set_req(1, 32'h0); bgnt = 4'b1110;
        at_neg(); chk("A stall breq", 32'(breq), 32'h1); chk("A stall gnt", 32'(gnt), 32'h0);
        next_cycle();
        bgnt = 4'hF;
        at_neg(); chk("A gnt1", 32'(gnt), 32'h2);
        next_cycle();
        addr[63:32] = 32'h0C;
        for (int k = 0; k < 2; k++) begin
            at_neg(); chk("A hold gnt", 32'(gnt), 32'h0); chk("A hold breq", 32'(breq), 32'h0);
            next_cycle();
        end
        brv = 4'b0001; brdata[31:0] = 32'h5A5A_0000;
        at_neg();
        chk("A rsp rvalid", 32'(rvalid), 32'h2); chk("A rsp rdata", rdata[63:32], 32'h5A5A_0000);
        chk("A switch gnt", 32'(gnt), 32'h2); chk("A switch breq", 32'(breq), 32'h8);
        $display("seq A: bank0 response and bank3 grant same cycle gnt=%b", gnt);
        next_cycle();
        drive_idle(); brv = 4'b1000; brdata[127:96] = 32'h5A5A_0003;
        at_neg();
        chk("A b3 rvalid", 32'(rvalid), 32'h2); chk("A b3 rdata", rdata[63:32], 32'h5A5A_0003);
        next_cycle();

        // Outstanding limit: four in flight on bank 0, fifth waits for a response.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(2, 32'(16 * k));
            at_neg(); chk($sformatf("B issue%0d gnt", k), 32'(gnt), 32'h4);
            chk($sformatf("B issue%0d baddr", k), baddr[31:0], 32'(4 * k));
            next_cycle();
        end
        set_req(2, 32'h40);
        for (int k = 0; k < 2; k++) begin
            at_neg(); chk("B limit gnt", 32'(gnt), 32'h0); chk("B limit breq", 32'(breq), 32'h0);
            next_cycle();
        end
        brv = 4'b0001; brdata[31:0] = 32'hB0B0_0000;
        at_neg();
        chk("B first rvalid", 32'(rvalid), 32'h4); chk("B first rdata", rdata[95:64], 32'hB0B0_0000);
        chk("B still blocked", 32'(gnt), 32'h0);
        next_cycle();
        brv = '0;
        at_neg(); chk("B fifth gnt", 32'(gnt), 32'h4); chk("B no rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        req = '0;
        for (int k = 1; k <= 4; k++) begin
            brv = 4'b0001; brdata[31:0] = 32'hB0B0_0000 + 32'(k);
            at_neg();
            chk($sformatf("B drain%0d rvalid", k), 32'(rvalid), 32'h4);
            chk($sformatf("B drain%0d rdata", k), rdata[95:64], 32'hB0B0_0000 + 32'(k));
            next_cycle();
        end
        $display("seq B: outstanding limit sequence done");

        // Reset with three requests in flight, stale responses dropped.
        do_reset();
        set_req(0, 32'h00); set_req(1, 32'h04); set_req(3, 32'h0C);
        at_neg(); chk("C issue gnt", 32'(gnt), 32'hB);
        next_cycle();
        rst_n = 1'b0; brv = 4'b0001;
        at_neg();
        chk("C rst gnt", 32'(gnt), 32'h0); chk("C rst breq", 32'(breq), 32'h0);
        chk("C rst rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        rst_n = 1'b1; drive_idle(); brv = 4'b1010; brdata = {4{32'hDEAD_0000}};
        at_neg(); chk("C stale rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        drive_idle();
        set_req(1, 32'h04); we[1] = 1'b1; be[7:4] = 4'hA; wdata[63:32] = 32'hDEAD_BEEF;
        set_req(0, 32'h08);
        at_neg();
        chk("C new gnt", 32'(gnt), 32'h3); chk("C new breq", 32'(breq), 32'h6);
        chk("C we", 32'(bwe[1]), 32'h1); chk("C be", 32'(bbe[7:4]), 32'hA);
        chk("C wdata", bwdata[63:32], 32'hDEAD_BEEF);
        next_cycle();
        drive_idle(); brv = 4'b0110; brdata[63:32] = 32'h1111_1111; brdata[95:64] = 32'h2222_2222;
        at_neg();
        chk("C rsp rvalid", 32'(rvalid), 32'h3);
        chk("C rsp rdata0", rdata[31:0], 32'h2222_2222); chk("C rsp rdata1", rdata[63:32], 32'h1111_1111);
        $display("seq C: reset recovery rvalid=%b", rvalid);
        next_cycle();
        drive_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
